intr_ctrl: RTL and testbench

Interrupt source/controller that drives the `interrupt` request into the program-counter controller and consumes its handshake.
- Synchronises and edge-detects external IRQ lines into sticky pending bits; software may also set pending bits.
- Applies per-line and global enables, holds a level request until the PC controller acknowledges entry to the vector via `save_accum`, then latches the cause.
- Stays masked until the ISR's return retires. No nesting.
- CPU access is through a small 4-register memory-mapped port.

---
 rtl/intr_pkg.sv | 20 ++
 rtl/intr_ctrl_if.sv | 22 ++
 rtl/irq_sync_edge.sv | 31 +++
 rtl/intr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_intr_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_pkg.sv
// Shared constants and state encoding for the interrupt controller slice.
package intr_pkg;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_SPURIOUS = 4'b1000;

  localparam int GIE_BIT   = 7;
  localparam int INSVC_BIT = 6;

endpackage

// File: rtl/intr_ctrl_if.sv
// Register port plus PC-controller handshake of the interrupt controller.
interface intr_ctrl_if;
  logic       reg_write;
  logic [1:0] reg_addr;
  logic [7:0] reg_writedata;
  logic [7:0] reg_readdata;
  logic       save_accum;
  logic       ret_taken;
  logic       interrupt;
  logic       in_service;
  logic [3:0] cause;

  modport master (
    output reg_write, reg_addr, reg_writedata, save_accum, ret_taken,
    input  reg_readdata, interrupt, in_service, cause
  );

  modport slave (
    input  reg_write, reg_addr, reg_writedata, save_accum, ret_taken,
    output reg_readdata, interrupt, in_service, cause
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Synchroniser chain for one asynchronous IRQ line with a one-cycle rise pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: sticky pending bits, enables, level request to the PC
// controller held until save_accum, single-level service until ret retires.
//
//   state   | meaning
//   IDLE    | no request; waiting for gie & enabled pending
//   REQ     | request held until save_accum (never withdrawn)
//   SERVICE | ISR running; masked until ret_taken
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  input  logic               stopped,
  input  logic [NUM_IRQ-1:0] irq_in,
  intr_ctrl_if.slave         bus
);

  state_e             state_q, state_d;
  logic               req_flag_q, req_flag_d;
  logic               in_service_q, in_service_d;
  logic [3:0]         cause_q, cause_d;
  logic               gie_q, gie_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] wdata_n;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] w1c;
  logic               wr_en;
  logic               run;
  logic               qual;
  logic [7:0]         rdata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (irq_in[g]),
      .rise_pulse (rise[g])
    );
  end

  function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  assign wr_en   = bus.reg_write & ~pause;
  assign run     = ~pause & ~stopped;
  assign wdata_n = bus.reg_writedata[NUM_IRQ-1:0];
  assign masked  = pending_q & enable_q;
  assign qual    = gie_q & (|masked);

  always_comb begin
    state_d      = state_q;
    req_flag_d   = req_flag_q;
    in_service_d = in_service_q;
    cause_d      = cause_q;
    enable_d     = enable_q;
    gie_d        = gie_q;
    ack_clr      = '0;
    sw_set       = '0;
    w1c          = '0;

    if (wr_en) begin
      case (bus.reg_addr)
        ADDR_ENABLE:  enable_d = wdata_n;
        ADDR_PENDING: w1c      = wdata_n;
        ADDR_STATUS:  gie_d    = bus.reg_writedata[GIE_BIT];
        ADDR_SWTRIG:  sw_set   = wdata_n;
        default:      ;
      endcase
    end

    if (run) begin
      case (state_q)
        IDLE: begin
          if (qual) begin
            state_d    = REQ;
            req_flag_d = 1'b1;
          end
        end
        REQ: begin
          if (bus.save_accum) begin
            state_d      = SERVICE;
            req_flag_d   = 1'b0;
            in_service_d = 1'b1;
            // Pending may have been cleared by software after commit: spurious.
            if (qual) begin
              cause_d = {1'b0, lowest_set(masked)};
              ack_clr = NUM_IRQ'(1) << lowest_set(masked);
            end else begin
              cause_d = CAUSE_SPURIOUS;
            end
          end
        end
        SERVICE: begin
          if (bus.ret_taken) begin
            state_d      = IDLE;
            in_service_d = 1'b0;
          end
        end
        default: begin
          state_d    = IDLE;
          req_flag_d = 1'b0;
        end
      endcase
    end

    // Sets win over clears in the same cycle.
    pending_d = (pending_q & ~(w1c | ack_clr)) | rise | sw_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_flag_q   <= 1'b0;
      in_service_q <= 1'b0;
      cause_q      <= 4'd0;
      gie_q        <= 1'b0;
      enable_q     <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_flag_q   <= req_flag_d;
      in_service_q <= in_service_d;
      cause_q      <= cause_d;
      gie_q        <= gie_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    rdata = 8'd0;
    case (bus.reg_addr)
      ADDR_ENABLE:  rdata[NUM_IRQ-1:0] = enable_q;
      ADDR_PENDING: rdata[NUM_IRQ-1:0] = pending_q;
      ADDR_STATUS: begin
        rdata[GIE_BIT]   = gie_q;
        rdata[INSVC_BIT] = in_service_q;
        rdata[3:0]       = cause_q;
      end
      default:      rdata = 8'd0;
    endcase
  end

  // Gate with save_accum so the PC controller never re-samples in the ack cycle.
  assign bus.interrupt    = req_flag_q & ~bus.save_accum & ~stopped;
  assign bus.reg_readdata = rdata;
  assign bus.in_service   = in_service_q;
  assign bus.cause        = cause_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus a randomized
// service loop checked against a pending-set model.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       stopped = 1'b0;
  logic [7:0] irq_in = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  intr_ctrl_if bus ();

  intr_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .pause   (pause),
    .stopped (stopped),
    .irq_in  (irq_in),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq_in = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_write = 1'b1;
    bus.reg_addr = a;
    bus.reg_writedata = d;
    step();
    bus.reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_readdata;
  endtask

  task automatic wait_int(input int budget);
    int n = 0;
    while (bus.interrupt !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    n_vec++;
    if (bus.interrupt !== 1'b1) begin
      n_err++;
      $display("FAIL wait_int: interrupt=%b after %0d cycles, required 1", bus.interrupt, n);
    end
  endtask

  task automatic ack();
    bus.save_accum = 1'b1;
    #1;
    n_vec++;
    if (bus.interrupt !== 1'b0) begin
      n_err++;
      $display("FAIL ack_gate: interrupt=%b during save_accum, required 0", bus.interrupt);
    end
    step();
    bus.save_accum = 1'b0;
  endtask

  task automatic ret();
    bus.ret_taken = 1'b1;
    step();
    bus.ret_taken = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    n_vec++;
    if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0 || bus.cause !== 4'h0) begin
      n_err++;
      $display("FAIL reset_outputs: int=%b insvc=%b cause=%h, required 0 0 0",
               bus.interrupt, bus.in_service, bus.cause);
    end
    reg_rd(ADDR_ENABLE, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL reset_enable: got %h required 00", d); end
    reg_rd(ADDR_STATUS, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h required 00", d); end
  endtask

  task automatic test_basic_edge();
    logic [7:0] d;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'h04);
    reg_wr(ADDR_STATUS, 8'h80);
    irq_in[2] = 1'b1;
    step();
    step();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL t1_pending_early: got %h required 00", d); end
    step();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (d !== 8'h04) begin n_err++; $display("FAIL t1_pending: got %h required 04", d); end
    n_vec++;
    if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL t1_int_early: got %b required 0", bus.interrupt); end
    step();
    n_vec++;
    if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL t1_int: got %b required 1", bus.interrupt); end
    ack();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (bus.cause !== 4'h2 || bus.in_service !== 1'b1 || d !== 8'h00) begin
      n_err++;
      $display("FAIL t1_ack: cause=%h insvc=%b pend=%h required 2 1 00", bus.cause, bus.in_service, d);
    end
    reg_rd(ADDR_STATUS, d);
    n_vec++;
    if (d !== 8'hC2) begin n_err++; $display("FAIL t1_status: got %h required c2", d); end
    irq_in[2] = 1'b0;
    ret();
  endtask

  task automatic test_priority();
    logic [7:0] d;
    int n;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'hFF);
    reg_wr(ADDR_SWTRIG, 8'h28);
    reg_rd(ADDR_SWTRIG, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL t2_swtrig_read: got %h required 00", d); end
    reg_wr(ADDR_STATUS, 8'h80);
    wait_int(10);
    ack();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (bus.cause !== 4'h3 || d !== 8'h20) begin
      n_err++;
      $display("FAIL t2_first: cause=%h pend=%h required 3 20", bus.cause, d);
    end
    ret();
    n_vec++;
    if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL t2_ret: insvc=%b required 0", bus.in_service); end
    n = 0;
    while (bus.interrupt !== 1'b1 && n < 2) begin
      step();
      n++;
    end
    n_vec++;
    if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL t2_reassert: int=%b after %0d cycles required 1", bus.interrupt, n); end
    ack();
    n_vec++;
    if (bus.cause !== 4'h5) begin n_err++; $display("FAIL t2_second: cause=%h required 5", bus.cause); end
    ret();
  endtask

  task automatic test_spurious();
    logic [7:0] d;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'h01);
    reg_wr(ADDR_SWTRIG, 8'h01);
    reg_wr(ADDR_STATUS, 8'h80);
    wait_int(10);
    reg_wr(ADDR_PENDING, 8'hFF);
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (bus.interrupt !== 1'b1 || d !== 8'h00) begin
      n_err++;
      $display("FAIL t3_hold: int=%b pend=%h required 1 00", bus.interrupt, d);
    end
    ack();
    n_vec++;
    if (bus.cause !== CAUSE_SPURIOUS || bus.in_service !== 1'b1) begin
      n_err++;
      $display("FAIL t3_spurious: cause=%h insvc=%b required 8 1", bus.cause, bus.in_service);
    end
    ret();
  endtask

  task automatic test_pause_service();
    logic [7:0] d;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'h03);
    reg_wr(ADDR_SWTRIG, 8'h02);
    reg_wr(ADDR_STATUS, 8'h80);
    wait_int(10);
    ack();
    n_vec++;
    if (bus.cause !== 4'h1) begin n_err++; $display("FAIL t4_first: cause=%h required 1", bus.cause); end
    pause = 1'b1;
    irq_in[0] = 1'b1;
    reg_wr(ADDR_ENABLE, 8'h00);
    repeat (4) step();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (d !== 8'h01) begin n_err++; $display("FAIL t4_pend_paused: got %h required 01", d); end
    reg_rd(ADDR_ENABLE, d);
    n_vec++;
    if (d !== 8'h03) begin n_err++; $display("FAIL t4_enable_hold: got %h required 03", d); end
    n_vec++;
    if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b1) begin
      n_err++;
      $display("FAIL t4_paused: int=%b insvc=%b required 0 1", bus.interrupt, bus.in_service);
    end
    pause = 1'b0;
    repeat (2) step();
    n_vec++;
    if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL t4_masked: int=%b required 0", bus.interrupt); end
    ret();
    wait_int(4);
    ack();
    n_vec++;
    if (bus.cause !== 4'h0) begin n_err++; $display("FAIL t4_line0: cause=%h required 0", bus.cause); end
    irq_in[0] = 1'b0;
    ret();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'h02);
    reg_wr(ADDR_SWTRIG, 8'h02);
    reg_wr(ADDR_STATUS, 8'h80);
    wait_int(10);
    irq_in[1] = 1'b1;
    step();
    step();
    ack();
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (bus.cause !== 4'h1 || d !== 8'h02) begin
      n_err++;
      $display("FAIL t5_set_beats_ack: cause=%h pend=%h required 1 02", bus.cause, d);
    end
    irq_in[1] = 1'b0;
    ret();
  endtask

  task automatic test_reset_stopped();
    logic [7:0] d;
    do_reset();
    reg_wr(ADDR_ENABLE, 8'h01);
    reg_wr(ADDR_SWTRIG, 8'h01);
    reg_wr(ADDR_STATUS, 8'h80);
    wait_int(10);
    stopped = 1'b1;
    #1;
    n_vec++;
    if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL t6_stop_gate: int=%b required 0", bus.interrupt); end
    stopped = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0) begin
      n_err++;
      $display("FAIL t6_reset_int: int=%b insvc=%b required 0 0", bus.interrupt, bus.in_service);
    end
    reg_rd(ADDR_PENDING, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL t6_reset_pend: got %h required 00", d); end
    reg_rd(ADDR_STATUS, d);
    n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL t6_reset_gie: status=%h required 00", d); end
    step();
    n_vec++;
    if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL t6_idle: int=%b required 0", bus.interrupt); end
    stopped = 1'b1;
    reg_wr(ADDR_ENABLE, 8'h01);
    reg_wr(ADDR_SWTRIG, 8'h01);
    reg_wr(ADDR_STATUS, 8'h80);
    repeat (3) step();
    n_vec++;
    if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL t6_stopped: int=%b required 0", bus.interrupt); end
    stopped = 1'b0;
    wait_int(4);
    ack();
    ret();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] en, sw, hw, pend;
    int idx;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      en = 8'($urandom_range(1, 255));
      sw = 8'($urandom);
      hw = 8'($urandom);
      reg_wr(ADDR_ENABLE, en);
      reg_wr(ADDR_SWTRIG, sw);
      irq_in = hw;
      repeat (4) step();
      irq_in = 8'h00;
      pend = sw | hw;
      reg_rd(ADDR_PENDING, d);
      n_vec++;
      if (d !== pend) begin n_err++; $display("FAIL rnd_pend_init[%0d]: got %h required %h", it, d, pend); end
      reg_wr(ADDR_STATUS, 8'h80);
      while ((pend & en) != 8'h00) begin
        idx = 0;
        while (((pend & en) >> idx) % 2 == 0) idx++;
        wait_int(10);
        ack();
        n_vec++;
        if (bus.cause !== 4'(idx)) begin
          n_err++;
          $display("FAIL rnd_cause[%0d]: got %h required %h", it, bus.cause, 4'(idx));
        end
        pend = pend & ~(8'h01 << idx);
        ret();
      end
      repeat (3) step();
      reg_rd(ADDR_PENDING, d);
      n_vec++;
      if (bus.interrupt !== 1'b0 || d !== pend) begin
        n_err++;
        $display("FAIL rnd_drain[%0d]: int=%b pend=%h required 0 %h", it, bus.interrupt, d, pend);
      end
    end
  endtask

  initial begin
    bus.reg_write = 1'b0;
    bus.reg_addr = 2'd0;
    bus.reg_writedata = 8'h00;
    bus.save_accum = 1'b0;
    bus.ret_taken = 1'b0;
    test_reset();
    test_basic_edge();
    test_priority();
    test_spurious();
    test_pause_service();
    test_back_to_back();
    test_reset_stopped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
